// File: rtl/seg_display_pkg.sv
// Shared constants, FSM state type and segment encoder for the 7-segment display sequencer.
// Segment patterns are active-low, bit order gfedcba.
package seg_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int SHIFT_CYCLES = 7;
    localparam int OVF_LIMIT    = 99;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_COMMIT
    } state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration for a 7-bit binary value and a 2-digit BCD accumulator:
// add 3 to any BCD nibble >= 5, then shift {bcd, bin} left by one.
module bin2bcd_step (
    input  logic [6:0] bin_i,
    input  logic [7:0] bcd_i,
    output logic [6:0] bin_o,
    output logic [7:0] bcd_o
);

    logic [3:0] tens_adj;
    logic [3:0] ones_adj;

    always_comb begin
        tens_adj = (bcd_i[7:4] >= 4'd5) ? bcd_i[7:4] + 4'd3 : bcd_i[7:4];
        ones_adj = (bcd_i[3:0] >= 4'd5) ? bcd_i[3:0] + 4'd3 : bcd_i[3:0];
        bcd_o    = {tens_adj[2:0], ones_adj, bin_i[6]};
        bin_o    = {bin_i[5:0], 1'b0};
    end

endmodule

// File: rtl/seg_display_sequencer.sv
// Sequenced 7-segment display path: captures rs/rt/ALU on req, converts each to two decimal
// digits with a shared double-dabble step, and commits all displays atomically with a counter.
module seg_display_sequencer
    import seg_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit CNT_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        clear,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] alu_val,
    output logic        busy,
    output logic        done,
    output logic [6:0]  HEX7,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam logic [6:0] POL_MASK = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;

    state_e                state_q, state_d;
    logic [1:0]            op_idx_q, op_idx_d;
    logic [2:0]            shift_cnt_q, shift_cnt_d;
    logic [6:0]            bin_q, bin_d, step_bin;
    logic [7:0]            bcd_q, bcd_d, step_bcd;
    logic                  ovf_q, ovf_d;
    logic [2:0][31:0]      opnd_q, opnd_d;
    logic [2:0][31:0]      pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [2:0][1:0][6:0]  stage_q, stage_d;
    logic [2:0][1:0][6:0]  disp_q, disp_d;
    logic [3:0]            cnt_tens_q, cnt_tens_d;
    logic [3:0]            cnt_ones_q, cnt_ones_d;
    logic                  done_q, done_d;

    logic [2:0][31:0]      req_opnd;
    logic [31:0]           cur_opnd;
    logic                  cur_ovf;

    // Operand slot 0 = rs, 1 = rt, 2 = ALU result.
    assign req_opnd = {alu_val, rt_val, rs_val};
    assign cur_opnd = opnd_q[op_idx_q];
    assign cur_ovf  = (cur_opnd > 32'(OVF_LIMIT));

    bin2bcd_step u_step (
        .bin_i (bin_q),
        .bcd_i (bcd_q),
        .bin_o (step_bin),
        .bcd_o (step_bcd)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d      = state_q;
        op_idx_d     = op_idx_q;
        shift_cnt_d  = shift_cnt_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        opnd_d       = opnd_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        stage_d      = stage_q;
        disp_d       = disp_q;
        cnt_tens_d   = cnt_tens_q;
        cnt_ones_d   = cnt_ones_q;
        done_d       = 1'b0;

        if (clear) begin
            state_d      = ST_IDLE;
            pend_valid_d = 1'b0;
            disp_d       = {6{SEG_0}};
        end else begin
            // A request arriving mid-conversion waits in the slot; the newest one wins.
            if (req && state_q != ST_IDLE && state_q != ST_COMMIT) begin
                pend_d       = req_opnd;
                pend_valid_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        opnd_d   = req_opnd;
                        op_idx_d = 2'd0;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ovf_d = cur_ovf;
                    if (!cur_ovf) begin
                        bin_d = cur_opnd[6:0];
                        bcd_d = 8'd0;
                    end
                    shift_cnt_d = 3'd0;
                    state_d     = ST_SHIFT;
                end
                ST_SHIFT: begin
                    bin_d       = step_bin;
                    bcd_d       = step_bcd;
                    shift_cnt_d = shift_cnt_q + 3'd1;
                    if (shift_cnt_q == 3'(SHIFT_CYCLES - 1)) state_d = ST_STORE;
                end
                ST_STORE: begin
                    stage_d[op_idx_q] = ovf_q ? {SEG_DASH, SEG_DASH}
                                              : {seg_encode(bcd_q[7:4]), seg_encode(bcd_q[3:0])};
                    if (op_idx_q != 2'd2) begin
                        op_idx_d = op_idx_q + 2'd1;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d  = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_d = stage_q;
                    done_d = 1'b1;
                    if (cnt_ones_q == 4'd9) begin
                        cnt_ones_d = 4'd0;
                        cnt_tens_d = (cnt_tens_q == 4'd9) ? 4'd0 : cnt_tens_q + 4'd1;
                    end else begin
                        cnt_ones_d = cnt_ones_q + 4'd1;
                    end
                    // A request in this very cycle is newer than the slot and is served first.
                    if (req || pend_valid_q) begin
                        opnd_d       = req ? req_opnd : pend_q;
                        pend_valid_d = 1'b0;
                        op_idx_d     = 2'd0;
                        state_d      = ST_LOAD;
                    end else begin
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= ST_IDLE;
            op_idx_q     <= 2'd0;
            shift_cnt_q  <= 3'd0;
            ovf_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            stage_q      <= {6{SEG_0}};
            disp_q       <= {6{SEG_0}};
            cnt_tens_q   <= 4'd0;
            cnt_ones_q   <= 4'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_idx_q     <= op_idx_d;
            shift_cnt_q  <= shift_cnt_d;
            ovf_q        <= ovf_d;
            pend_valid_q <= pend_valid_d;
            stage_q      <= stage_d;
            disp_q       <= disp_d;
            cnt_tens_q   <= cnt_tens_d;
            cnt_ones_q   <= cnt_ones_d;
            done_q       <= done_d;
        end
    end

    // NOTE: operand and shift datapath is left unreset; it is always loaded before it is read.
    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        pend_q <= pend_d;
        bin_q  <= bin_d;
        bcd_q  <= bcd_d;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    assign HEX7 = disp_q[0][1] ^ POL_MASK;
    assign HEX6 = disp_q[0][0] ^ POL_MASK;
    assign HEX5 = disp_q[1][1] ^ POL_MASK;
    assign HEX4 = disp_q[1][0] ^ POL_MASK;
    assign HEX3 = (CNT_EN ? seg_encode(cnt_tens_q) : SEG_BLANK) ^ POL_MASK;
    assign HEX2 = (CNT_EN ? seg_encode(cnt_ones_q) : SEG_BLANK) ^ POL_MASK;
    assign HEX1 = disp_q[2][1] ^ POL_MASK;
    assign HEX0 = disp_q[2][0] ^ POL_MASK;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Self-checking bench for seg_display_sequencer: randomized requests against a decimal
// display model, plus pending-slot, clear and counter-wrap scenarios.
module tb_seg_display_sequencer;

    logic        clk = 1'b0;
    logic        reset, req, clear;
    logic [31:0] rs_val, rt_val, alu_val;
    logic        busy, done;
    logic [6:0]  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    logic [6:0] seg_tab [0:9];
    localparam logic [6:0] DASH = 7'b0111111;

    seg_display_sequencer #(
        .SEG_ACTIVE_LOW (1'b1),
        .CNT_EN         (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .clear   (clear),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .alu_val (alu_val),
        .busy    (busy),
        .done    (done),
        .HEX7    (HEX7),
        .HEX6    (HEX6),
        .HEX5    (HEX5),
        .HEX4    (HEX4),
        .HEX3    (HEX3),
        .HEX2    (HEX2),
        .HEX1    (HEX1),
        .HEX0    (HEX0)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    function automatic logic [55:0] hex_bus();
        return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // Two displayed digits for an unsigned operand: decimal value, or dashes above 99.
    function automatic logic [13:0] pair_of(input logic [31:0] v);
        int iv;
        if (v > 32'd99) return {DASH, DASH};
        iv = int'(v);
        return {seg_tab[iv / 10], seg_tab[iv % 10]};
    endfunction

    function automatic logic [55:0] expect_hex(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input int cnt);
        return {pair_of(a), pair_of(b), seg_tab[cnt / 10], seg_tab[cnt % 10], pair_of(c)};
    endfunction

    task automatic apply_reset();
        req = 1'b0; clear = 1'b0;
        rs_val = '0; rt_val = '0; alu_val = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
    endtask

    // Issues one request from a negedge and observes the conversion until done.
    task automatic do_conversion(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 output int lat, output int busy_bad, output logic [55:0] hex_at_done,
                                 output logic busy_at_done, output logic done_next);
        lat = -1; busy_bad = 0; hex_at_done = '0; busy_at_done = 1'b1;
        @(negedge clk);
        req = 1'b1; rs_val = a; rt_val = b; alu_val = c;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (done) begin
                lat = k - 1;
                hex_at_done = hex_bus();
                busy_at_done = busy;
                break;
            end
            if (!busy) busy_bad++;
        end
        @(negedge clk);
        done_next = done;
        if (lat >= 0) model_cnt = (model_cnt + 1) % 100;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (hex_bus() !== {8{seg_tab[0]}}) begin
            n_err++;
            $display("FAIL reset_hex: got %h, required %h", hex_bus(), {8{seg_tab[0]}});
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b done=%b, required busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, busy_bad;
        logic [55:0] h;
        logic b_at, d_next;
        do_conversion(32'd42, 32'd7, 32'd49, lat, busy_bad, h, b_at, d_next);
        n_cmp++;
        if (lat !== 28) begin
            n_err++;
            $display("FAIL basic_latency: got %0d, required 28", lat);
        end
        n_cmp++;
        if (busy_bad !== 0) begin
            n_err++;
            $display("FAIL basic_busy: got %0d idle cycles during conversion, required 0", busy_bad);
        end
        n_cmp++;
        if (h !== {7'b0011001, 7'b0100100, 7'b1000000, 7'b1111000,
                   7'b1000000, 7'b1111001, 7'b0011001, 7'b0010000}) begin
            n_err++;
            $display("FAIL basic_hex: got %h, required 42/07/01/49 patterns", h);
        end
        n_cmp++;
        if (b_at !== 1'b0 || d_next !== 1'b0) begin
            n_err++;
            $display("FAIL basic_handshake: got busy=%b done_next=%b, required 0 0", b_at, d_next);
        end
    endtask

    task automatic test_overflow();
        int lat, busy_bad;
        logic [55:0] h;
        logic b_at, d_next;
        do_conversion(32'd100, 32'd99, 32'hFFFF_FFFF, lat, busy_bad, h, b_at, d_next);
        n_cmp++;
        if (lat !== 28) begin
            n_err++;
            $display("FAIL ovf_latency: got %0d, required 28", lat);
        end
        n_cmp++;
        if (h !== expect_hex(32'd100, 32'd99, 32'hFFFF_FFFF, model_cnt)) begin
            n_err++;
            $display("FAIL ovf_hex: got %h, required %h", h,
                     expect_hex(32'd100, 32'd99, 32'hFFFF_FFFF, model_cnt));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] c [3];
        int ndone = 0, t1 = -1, t2 = -1;
        logic [55:0] h1 = '0, h2 = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom_range(0, 99); b[i] = $urandom_range(0, 99); c[i] = $urandom_range(0, 99);
        end
        @(negedge clk);
        req = 1'b1; rs_val = a[0]; rt_val = b[0]; alu_val = c[0];
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (k == 5)  begin req = 1'b1; rs_val = a[1]; rt_val = b[1]; alu_val = c[1]; end
            if (k == 10) begin req = 1'b1; rs_val = a[2]; rt_val = b[2]; alu_val = c[2]; end
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = k - 1; h1 = hex_bus(); end
                if (ndone == 2) begin t2 = k - 1; h2 = hex_bus(); end
            end
        end
        n_cmp++;
        if (ndone !== 2) begin
            n_err++;
            $display("FAIL b2b_commits: got %0d, required 2", ndone);
        end
        n_cmp++;
        if (t1 !== 28 || h1 !== expect_hex(a[0], b[0], c[0], (model_cnt + 1) % 100)) begin
            n_err++;
            $display("FAIL b2b_first: got t=%0d hex=%h, required t=28 hex=%h", t1, h1,
                     expect_hex(a[0], b[0], c[0], (model_cnt + 1) % 100));
        end
        n_cmp++;
        if (t2 !== 56 || h2 !== expect_hex(a[2], b[2], c[2], (model_cnt + 2) % 100)) begin
            n_err++;
            $display("FAIL b2b_latest: got t=%0d hex=%h, required t=56 hex=%h", t2, h2,
                     expect_hex(a[2], b[2], c[2], (model_cnt + 2) % 100));
        end
        model_cnt = (model_cnt + 2) % 100;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_clear();
        int lat, busy_bad, ndone;
        logic [55:0] h;
        logic b_at, d_next;
        logic [55:0] zero_vals;
        zero_vals = expect_hex(32'd0, 32'd0, 32'd0, model_cnt);
        @(negedge clk);
        req = 1'b1; rs_val = 32'd11; rt_val = 32'd22; alu_val = 32'd33;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            req = 1'b0;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (hex_bus() !== zero_vals || busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_abort: got hex=%h busy=%b, required hex=%h busy=0",
                     hex_bus(), busy, zero_vals);
        end
        // clear and req together: the request must be discarded.
        clear = 1'b1; req = 1'b1; rs_val = 32'd5; rt_val = 32'd6; alu_val = 32'd7;
        @(negedge clk);
        clear = 1'b0; req = 1'b0;
        ndone = 0;
        for (int k = 0; k < 35; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        n_cmp++;
        if (ndone !== 0 || hex_bus() !== zero_vals) begin
            n_err++;
            $display("FAIL clear_wins: got %0d busy/done cycles hex=%h, required 0 and %h",
                     ndone, hex_bus(), zero_vals);
        end
        do_conversion(32'd58, 32'd100, 32'd3, lat, busy_bad, h, b_at, d_next);
        n_cmp++;
        if (lat !== 28 || h !== expect_hex(32'd58, 32'd100, 32'd3, model_cnt)) begin
            n_err++;
            $display("FAIL clear_recover: got lat=%0d hex=%h, required 28 %h", lat, h,
                     expect_hex(32'd58, 32'd100, 32'd3, model_cnt));
        end
    endtask

    task automatic test_random();
        int lat, busy_bad;
        logic [55:0] h;
        logic b_at, d_next;
        logic [31:0] v [3];
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < 3; j++)
                v[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 110));
            do_conversion(v[0], v[1], v[2], lat, busy_bad, h, b_at, d_next);
            n_cmp++;
            if (lat !== 28 || busy_bad !== 0 || d_next !== 1'b0
                || h !== expect_hex(v[0], v[1], v[2], model_cnt)) begin
                n_err++;
                $display("FAIL random_%0d: got lat=%0d busy_bad=%0d done_next=%b hex=%h, required 28 0 0 %h",
                         i, lat, busy_bad, d_next, h, expect_hex(v[0], v[1], v[2], model_cnt));
            end
        end
    endtask

    task automatic test_wrap();
        int ndone = 0, last_k = 0;
        apply_reset();
        @(negedge clk);
        req = 1'b1; rs_val = 32'd12; rt_val = 32'd34; alu_val = 32'd56;
        for (int k = 1; k <= 100 * 28 + 60; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                model_cnt = (model_cnt + 1) % 100;
                n_cmp++;
                if (k - last_k !== (ndone == 1 ? 29 : 28)
                    || hex_bus() !== expect_hex(32'd12, 32'd34, 32'd56, model_cnt)) begin
                    n_err++;
                    $display("FAIL wrap_commit_%0d: got gap=%0d hex=%h, required hex=%h", ndone,
                             k - last_k, hex_bus(), expect_hex(32'd12, 32'd34, 32'd56, model_cnt));
                end
                last_k = k;
                if (ndone == 100) break;
            end
        end
        req = 1'b0;
        n_cmp++;
        if (ndone !== 100 || {HEX3, HEX2} !== {seg_tab[0], seg_tab[0]}) begin
            n_err++;
            $display("FAIL wrap_final: got %0d commits counter=%h, required 100 commits counter=%h",
                     ndone, {HEX3, HEX2}, {seg_tab[0], seg_tab[0]});
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_clear();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_sequencer.md
Name: seg_display_sequencer

Overview:
- Sequenced replacement for the free-running 7-segment display path of the MIPS FPGA top.
- Captures the rs operand, rt operand and ALU result on a request strobe, and converts each to two decimal digits with an iterative double-dabble engine.
- Updates all segment outputs atomically when conversion is complete.
- Runs a busy/done handshake with the CPU step logic, holds one pending request, and keeps a 2-digit commit counter on HEX3/HEX2.

Parameters:
- SEG_ACTIVE_LOW, 1: 1 = segment patterns active-low (board default); 0 = every output pattern inverted.
- CNT_EN, 1: 1 = HEX3/HEX2 show the commit counter; 0 = HEX3/HEX2 held at the blank pattern.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  1  single-cycle display request; operands valid in the same cycle
- clear  in  1  force value displays to "00"; aborts any conversion in progress
- rs_val  in  32  operand 1, unsigned
- rt_val  in  32  operand 2, unsigned
- alu_val  in  32  ALU result, unsigned
- busy  out  1  high from the accepting edge until the commit edge
- done  out  1  one-cycle pulse in the cycle new HEX values first appear
- HEX7, HEX6  out  7 each  rs tens, ones
- HEX5, HEX4  out  7 each  rt tens, ones
- HEX3, HEX2  out  7 each  commit counter tens, ones
- HEX1, HEX0  out  7 each  ALU tens, ones

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - all HEX = "0" pattern 7'b1000000 (inverted if SEG_ACTIVE_LOW=0); HEX3/HEX2 blank 7'b1111111 if CNT_EN=0;
  - busy=0, done=0, commit counter=0;
  - pending slot empty; FSM=IDLE.
- Segment codes (active-low, gfedcba):
  - 0..9 = 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000;
  - overflow dash = 0111111; blank = 1111111.
- FSM states: IDLE, LOAD, SHIFT, STORE, COMMIT.
  - IDLE: req=1 -> latch the three operands, set op_idx=0, go to LOAD, busy=1.
  - LOAD: 1 cycle. If operand > 99, set the overflow flag for that operand. Otherwise load its low 7 bits into the shift register and clear the BCD register.
  - SHIFT: exactly 7 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift left by 1. Overflowed operands still spend 7 cycles, so timing is fixed.
  - STORE: 1 cycle. Write the digit pair (or dash/dash on overflow) to the staging register for op_idx. If op_idx<2, increment op_idx and go to LOAD; else go to COMMIT.
  - COMMIT: 1 cycle. Copy all staging digits to HEX7..4 and HEX1..0, and increment the counter (99 wraps to 0).
- Commit timing: HEX outputs, the new counter value and done=1 all appear after the COMMIT edge, at accept edge + 28. On that edge, go to LOAD if a request is pending (busy stays 1), else to IDLE with busy=0.
- Latency: 1 + 3*(1+7+1) = 28 clocks from the accepting edge to visible outputs. Fixed, independent of data.
- Pending slot (one deep):
  - req while busy latches its operands into the slot; a later req overwrites it (latest wins).
  - A req in the same cycle as COMMIT is captured into the slot and served immediately.
  - No requests are dropped except by overwrite or by clear.
- clear:
  - Any state -> next edge: HEX7..4 and HEX1..0 = "0" pattern, FSM=IDLE, busy=0, pending slot emptied, no done pulse.
  - The counter is not affected.
  - clear and req in the same cycle: clear wins, req is discarded.
- HEX outputs only change on COMMIT, clear or reset; they never show partial results.
- Operands are treated as unsigned 32-bit. Negative two's-complement values therefore display as dashes.

Decomposition:
- Package seg_display_pkg holds:
  - the 7-bit segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the FSM state enum;
  - localparams SHIFT_CYCLES=7 and OVF_LIMIT=99.
- One sub-module, bin2bcd_step: combinational add-3-and-shift of one double-dabble iteration (7-bit binary + 8-bit BCD in and out), instantiated once and reused across cycles.
- The segment encoding is a package function, not a separate module.

Test Plan:
- reset held 2 cycles -> all HEX=1000000, busy=0, done=0; counter shows 00.
- req with rs=42, rt=7, alu=49 -> busy=1 for 28 cycles; then HEX7/6=0011001/0100100, HEX5/4=1000000/1111000, HEX1/0=0011001/0010000, HEX3/2=00->01, done pulses once.
- req with rs=100, rt=99, alu=0xFFFFFFFF -> HEX7/6 dash, HEX5/4 "99", HEX1/0 dash; latency still 28.
- req A at cycle 0, req B at cycle 5, req C at cycle 10 -> A committed at cycle 28; C's values committed at cycle 56; B never displayed; counter +2.
- clear at cycle 15 of a conversion -> HEX value digits "00" next cycle, busy=0, no done; counter unchanged; a subsequent req converts normally.
- 100 back-to-back commits -> counter passes 99 and wraps to 00 on the 100th commit.
